// File: rtl/npc_predict_pkg.sv
// Shared encodings for the next-PC generator: select codes, counter type and
// the default reset fetch address.
package npc_predict_pkg;

   localparam logic [31:0] NPC_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      NPC_SEQ      = 2'd0,
      NPC_PRED     = 2'd1,
      NPC_HOLD     = 2'd2,
      NPC_REDIRECT = 2'd3
   } npc_sel_e;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_ALLOC = 2'b10;

   function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
      ctr_t r;
      r = c;
      if (taken && c != 2'b11) r = c + 2'd1;
      else if (!taken && c != 2'b00) r = c - 2'd1;
      return r;
   endfunction

endpackage

// File: rtl/npc_predict_if.sv
// Fetch-side bus: back-end corrections and training in, fetch PC and prediction out.
interface npc_predict_if #(parameter int XLEN = 32);

   logic            stall;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            upd_valid;
   logic [XLEN-1:0] upd_pc;
   logic [XLEN-1:0] upd_target;
   logic            upd_taken;
   logic            upd_jump;
   logic [XLEN-1:0] pc;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;

   modport master (
      output stall, redirect_valid, redirect_pc,
      output upd_valid, upd_pc, upd_target, upd_taken, upd_jump,
      input  pc, pred_taken, pred_target
   );

   modport slave (
      input  stall, redirect_valid, redirect_pc,
      input  upd_valid, upd_pc, upd_target, upd_taken, upd_jump,
      output pc, pred_taken, pred_target
   );

endinterface

// File: rtl/npc_predict_btb_dm.sv
// Direct-mapped BTB (btb_dm): combinational lookup port, synchronous training port.
// Reads see the registered array, so a same-cycle update is only visible next cycle.
module npc_predict_btb_dm
   import npc_predict_pkg::*;
#(
   parameter int  XLEN        = 32,
   parameter int  BTB_ENTRIES = 16,
   localparam int IDX_W       = $clog2(BTB_ENTRIES),
   localparam int TAG_W       = XLEN - IDX_W - 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] rd_pc,
   output logic            rd_hit,
   output logic [XLEN-1:0] rd_target,
   output ctr_t            rd_ctr,
   output logic            rd_jump,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_taken,
   input  logic            upd_jump
);

   logic [BTB_ENTRIES-1:0]            valid_q;
   logic [BTB_ENTRIES-1:0]            jump_q;
   logic [BTB_ENTRIES-1:0][1:0]       ctr_q;
   logic [BTB_ENTRIES-1:0][TAG_W-1:0] tag_q;
   logic [BTB_ENTRIES-1:0][XLEN-1:0]  tgt_q;

   logic [IDX_W-1:0] rd_idx, upd_idx;
   logic [TAG_W-1:0] rd_tag, upd_tag;
   logic             upd_hit;
   logic             unused_lsb;

   assign rd_idx     = rd_pc[IDX_W+1:2];
   assign rd_tag     = rd_pc[XLEN-1:IDX_W+2];
   assign upd_idx    = upd_pc[IDX_W+1:2];
   assign upd_tag    = upd_pc[XLEN-1:IDX_W+2];
   assign unused_lsb = ^{rd_pc[1:0], upd_pc[1:0]};

   assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign rd_target = tgt_q[rd_idx];
   assign rd_ctr    = ctr_q[rd_idx];
   assign rd_jump   = jump_q[rd_idx];

   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   // Tag/target/jump are never cleared: valid=0 makes them unobservable.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         ctr_q   <= '0;
      end else if (upd_valid) begin
         if (upd_hit) begin
            ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], upd_taken);
            if (upd_taken) begin
               tgt_q[upd_idx]  <= upd_target;
               jump_q[upd_idx] <= upd_jump;
            end
         end else if (upd_taken) begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            tgt_q[upd_idx]   <= upd_target;
            ctr_q[upd_idx]   <= CTR_ALLOC;
            jump_q[upd_idx]  <= upd_jump;
         end
      end
   end

endmodule

// File: rtl/npc_predict.sv
// Fetch PC register and next-PC priority mux: redirect > stall > BTB prediction > pc+4.
module npc_predict
   import npc_predict_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = NPC_RESET_PC,
   parameter int              BTB_ENTRIES = 16,
   localparam int             IDX_W       = $clog2(BTB_ENTRIES)
) (
   input  logic         clk,
   input  logic         rst,
   npc_predict_if.slave bus
);

   logic [XLEN-1:0] pc_q, pc_plus4, npc;
   logic            hit, jump, taken;
   logic [XLEN-1:0] tgt;
   ctr_t            ctr;
   npc_sel_e        sel;

   npc_predict_btb_dm #(
      .XLEN        (XLEN),
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk        (clk),
      .rst        (rst),
      .rd_pc      (pc_q),
      .rd_hit     (hit),
      .rd_target  (tgt),
      .rd_ctr     (ctr),
      .rd_jump    (jump),
      .upd_valid  (bus.upd_valid),
      .upd_pc     (bus.upd_pc),
      .upd_target (bus.upd_target),
      .upd_taken  (bus.upd_taken),
      .upd_jump   (bus.upd_jump)
   );

   assign pc_plus4 = pc_q + XLEN'(4);
   assign taken    = hit && (jump || ctr[1]);

   always_comb begin
      sel = NPC_SEQ;
      npc = pc_plus4;
      if (bus.redirect_valid) sel = NPC_REDIRECT;
      else if (bus.stall)     sel = NPC_HOLD;
      else if (taken)         sel = NPC_PRED;
      case (sel)
         NPC_REDIRECT: npc = bus.redirect_pc;
         NPC_HOLD:     npc = pc_q;
         NPC_PRED:     npc = tgt;
         default:      npc = pc_plus4;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) pc_q <= RESET_PC;
      else     pc_q <= npc;
   end

   assign bus.pc          = pc_q;
   assign bus.pred_taken  = taken;
   assign bus.pred_target = taken ? tgt : pc_plus4;

endmodule

// File: tb/tb_npc_predict.sv
// Directed bench for npc_predict: each stimulus cycle pushes the outputs expected
// in that cycle; a negedge monitor pops and compares them.
module tb_npc_predict;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   npc_predict_if #(.XLEN(32)) bus ();

   npc_predict #(
      .XLEN        (32),
      .RESET_PC    (32'h0000_0000),
      .BTB_ENTRIES (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [31:0] pc;
      logic        pt;
      logic [31:0] tg;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.nm, ".pc"}, bus.pc, e.pc);
            chk({e.nm, ".pred_taken"}, {31'd0, bus.pred_taken}, {31'd0, e.pt});
            chk({e.nm, ".pred_target"}, bus.pred_target, e.tg);
         end
      end
   end

   // r s rv rpc | uv upc utgt ut uj | expected pc, pred_taken, pred_target
   task automatic cyc(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                      input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                      input logic ut, input logic uj,
                      input logic [31:0] e_pc, input logic e_pt, input logic [31:0] e_tg,
                      input string nm);
      rst                = r;
      bus.stall          = s;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.upd_valid      = uv;
      bus.upd_pc         = upc;
      bus.upd_target     = utgt;
      bus.upd_taken      = ut;
      bus.upd_jump       = uj;
      sb.push_back('{e_pc, e_pt, e_tg, nm});
      @(posedge clk);
      #1;
   endtask

   initial begin : stim
      rst = 1'b1;
      bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
      bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_target = 0;
      bus.upd_taken = 0; bus.upd_jump = 0;
      @(posedge clk);
      #1;
      // reset and sequential fetch
      cyc(1,0,0,0,            0,0,0,0,0,               32'h0000_0000,0,32'h0000_0004,"rst");
      cyc(0,0,0,0,            0,0,0,0,0,               32'h0000_0000,0,32'h0000_0004,"seq0");
      cyc(0,0,0,0,            0,0,0,0,0,               32'h0000_0004,0,32'h0000_0008,"seq4");
      cyc(0,0,0,0,            0,0,0,0,0,               32'h0000_0008,0,32'h0000_000C,"seq8");
      cyc(0,0,0,0,            0,0,0,0,0,               32'h0000_000C,0,32'h0000_0010,"seq12");
      // redirect wins over stall, then stall holds
      cyc(0,1,1,32'h100,      0,0,0,0,0,               32'h0000_0010,0,32'h0000_0014,"redir_stall");
      cyc(0,1,0,0,            0,0,0,0,0,               32'h0000_0100,0,32'h0000_0104,"hold1");
      cyc(0,1,0,0,            0,0,0,0,0,               32'h0000_0100,0,32'h0000_0104,"hold2");
      // allocate 0x40 -> 0x200 (ctr=10)
      cyc(0,1,0,0,            1,32'h40,32'h200,1,0,    32'h0000_0100,0,32'h0000_0104,"alloc");
      cyc(0,0,1,32'h40,       0,0,0,0,0,               32'h0000_0100,0,32'h0000_0104,"idx0_miss");
      cyc(0,0,0,0,            0,0,0,0,0,               32'h0000_0040,1,32'h0000_0200,"pred40");
      // not-taken: ctr 10->01
      cyc(0,0,0,0,            1,32'h40,32'h200,0,0,    32'h0000_0200,0,32'h0000_0204,"at200");
      cyc(0,0,1,32'h40,       0,0,0,0,0,               32'h0000_0204,0,32'h0000_0208,"at204");
      // ctr=01 -> not taken; same-cycle taken update not yet visible (->10)
      cyc(0,0,0,0,            1,32'h40,32'h200,1,0,    32'h0000_0040,0,32'h0000_0044,"weak_nt_rdw");
      cyc(0,0,0,0,            1,32'h40,32'h200,1,0,    32'h0000_0044,0,32'h0000_0048,"at44");
      // ctr 11->10 alongside a redirect
      cyc(0,0,1,32'h40,       1,32'h40,32'h200,0,0,    32'h0000_0048,0,32'h0000_004C,"redir_upd");
      cyc(0,0,0,0,            0,0,0,0,0,               32'h0000_0040,1,32'h0000_0200,"hyst_taken");
      // tag alias at 0x80
      cyc(0,0,1,32'h80,       0,0,0,0,0,               32'h0000_0200,0,32'h0000_0204,"at200b");
      cyc(0,0,0,0,            0,0,0,0,0,               32'h0000_0080,0,32'h0000_0084,"alias80");
      // JAL at 0x10, then two not-taken updates (ctr 10->01->00)
      cyc(0,0,0,0,            1,32'h10,32'h300,1,1,    32'h0000_0084,0,32'h0000_0088,"at84");
      cyc(0,0,0,0,            1,32'h10,32'h300,0,1,    32'h0000_0088,0,32'h0000_008C,"at88");
      cyc(0,0,0,0,            1,32'h10,32'h300,0,1,    32'h0000_008C,0,32'h0000_0090,"at8c");
      cyc(0,0,1,32'h10,       0,0,0,0,0,               32'h0000_0090,0,32'h0000_0094,"alias90");
      cyc(0,0,0,0,            0,0,0,0,0,               32'h0000_0010,1,32'h0000_0300,"jal_ctr0");
      // wrap
      cyc(0,0,1,32'hFFFF_FFFC,0,0,0,0,0,               32'h0000_0300,0,32'h0000_0304,"at300");
      cyc(0,0,0,0,            0,0,0,0,0,               32'hFFFF_FFFC,0,32'h0000_0000,"wrap");
      // mid-run reset overrides redirect/stall/update and invalidates BTB
      cyc(1,1,1,32'h40,       1,32'h40,32'h500,1,0,    32'h0000_0000,0,32'h0000_0004,"rst_mid");
      cyc(0,0,1,32'h40,       0,0,0,0,0,               32'h0000_0000,0,32'h0000_0004,"post_rst");
      cyc(0,0,0,0,            0,0,0,0,0,               32'h0000_0040,0,32'h0000_0044,"btb_clear");
      cyc(0,0,0,0,            0,0,0,0,0,               32'h0000_0044,0,32'h0000_0048,"seq44");
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1;
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: timeout reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
